// File: rtl/decl_arb8_if.sv
// +-----------------------------------------------------------------------+
// | decl_arb8_if                                                          |
// | Request/grant bundle between eight requesters and the decl_arb8 core. |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

interface decl_arb8_if;
  logic [7:0] req;
  logic       en;
  logic [7:0] gnt_n;
  logic [2:0] gsel;
  logic       busy;
  logic       to_evt;

  modport master (
    output req, en,
    input  gnt_n, gsel, busy, to_evt
  );

  modport slave (
    input  req, en,
    output gnt_n, gsel, busy, to_evt
  );
endinterface

`default_nettype wire

// File: rtl/decl_arb8.sv
// +-----------------------------------------------------------------------+
// | decl_arb8                                                             |
// | Eight-way round-robin arbiter with active-low registered grants and a |
// | one-cycle dead slot between owners. Optional ownership timeout with   |
// | requester masking is built when ARB_TIMEOUT_EN is defined.            |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

module decl_arb8 (
  input  logic        clk,
  input  logic        reset,
  decl_arb8_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_n_q, gnt_n_d;
  logic [2:0] gsel_q,  gsel_d;
  logic [2:0] last_q,  last_d;
  logic       busy_q,  busy_d;

  logic [7:0] elig;
  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;

`ifdef ARB_TIMEOUT_EN
  logic [3:0] cnt_q,    cnt_d;
  logic [7:0] mask_q,   mask_d;
  logic       to_evt_q, to_evt_d;

  assign elig       = bus.req & ~mask_q;
  assign bus.to_evt = to_evt_q;
`else
  assign elig       = bus.req;
  assign bus.to_evt = 1'b0;
`endif

  // Offset 8 wraps back to last itself, so a sole requester is regranted.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    idx    = last_q;
    for (int k = 1; k <= 8; k++) begin
      idx = last_q + 3'(k);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_n_d  = gnt_n_q;
    gsel_d   = gsel_q;
    busy_d   = busy_q;
    last_d   = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    mask_d   = mask_q & bus.req;
    to_evt_d = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_TURN: begin
        if (bus.en && found) begin
          state_d = S_GRANT;
          gnt_n_d = ~(8'h01 << winner);
          gsel_d  = winner;
          busy_d  = 1'b1;
          last_d  = winner;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 4'd0;
`endif
        end else begin
          state_d = S_IDLE;
          gnt_n_d = 8'hFF;
          busy_d  = 1'b0;
        end
      end
      S_GRANT: begin
        if (!bus.req[gsel_q]) begin
          state_d = S_TURN;
          gnt_n_d = 8'hFF;
          busy_d  = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == 4'd15) begin
          state_d        = S_TURN;
          gnt_n_d        = 8'hFF;
          busy_d         = 1'b0;
          to_evt_d       = 1'b1;
          mask_d[gsel_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        gnt_n_d = 8'hFF;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_n_q  <= 8'hFF;
      gsel_q   <= 3'd0;
      busy_q   <= 1'b0;
      last_q   <= 3'd7;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= 4'd0;
      mask_q   <= 8'h00;
      to_evt_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_n_q  <= gnt_n_d;
      gsel_q   <= gsel_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      to_evt_q <= to_evt_d;
`endif
    end
  end

  assign bus.gnt_n = gnt_n_q;
  assign bus.gsel  = gsel_q;
  assign bus.busy  = busy_q;

endmodule

`default_nettype wire

// File: doc/decl_arb8.md
DECL_ARB8 -- requirements
Module: decl_arb8

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port req, input, 8 bits: request per requester; held high for the whole ownership period.
REQ-004 The block SHALL have port en, input, 1 bit: arbitration enable; when low, no new grant is issued.
REQ-005 The block SHALL have port gnt_n, output, 8 bits: registered active-low one-of-eight grant strobes.
REQ-006 The block SHALL have port gsel, output, 3 bits: binary index of the current owner, valid while busy is high.
REQ-007 The block SHALL have port busy, output, 1 bit: high while any gnt_n bit is low.
REQ-008 The block SHALL have port to_evt, output, 1 bit: one-cycle pulse on a forced release (see Configuration).

Function
REQ-009 The block SHALL implement a state machine with states IDLE, GRANT and TURN.
REQ-010 In IDLE or TURN with en=1 and req nonzero, the block SHALL pick the winner by round-robin, searching upward from (last+1) mod 8, and enter GRANT.
REQ-011 Round-robin search SHALL wrap from index 7 to index 0.
REQ-012 last SHALL update to the winner index on each grant.
REQ-013 Grant latency SHALL be one cycle: a request sampled at edge N drives gnt_n[winner]=0, gsel=winner and busy=1 after edge N.
REQ-014 At most one gnt_n bit SHALL be low in any cycle.
REQ-015 gnt_n and gsel SHALL be consistent: bit i is low exactly when gsel=i and busy=1.
REQ-016 In GRANT, the block SHALL stay in GRANT while req[gsel]=1, regardless of en or other requests.
REQ-017 In GRANT with req[gsel]=0 sampled, the block SHALL enter TURN with all gnt_n high and busy low, giving one dead cycle between owners.
REQ-018 From TURN, the block SHALL arbitrate per REQ-010, or go to IDLE if there is no eligible request or en=0.
REQ-019 If req falls and rises within the same grant, the release SHALL take effect only if the drop is sampled at a clock edge.
REQ-020 With en=0 in IDLE, the block SHALL stay in IDLE with outputs idle.
REQ-021 A requester SHALL NOT receive two consecutive grants while another request is pending.
REQ-022 A sole requester SHALL be regranted after the TURN cycle.

Reset
REQ-023 While reset=1, the block SHALL hold state=IDLE, gnt_n=8'hFF, gsel=0, busy=0, to_evt=0, last=7 (so index 0 wins first), timeout counter=0 and mask=0, independent of clk.
REQ-024 An assertion of reset during GRANT SHALL release the grant immediately, without waiting for a clock.
REQ-025 After reset deasserts, the first arbitration SHALL occur at the first clk edge.

Configuration
REQ-026 With macro ARB_TIMEOUT_EN defined, the block SHALL include a 4-bit counter that clears on entry to GRANT and increments each GRANT cycle.
REQ-027 With ARB_TIMEOUT_EN defined, when the counter equals 15 and req[gsel] is still 1, the block SHALL force TURN and pulse to_evt for one cycle coincident with TURN.
REQ-028 With ARB_TIMEOUT_EN defined, the block SHALL set mask[gsel] on a forced release; a masked requester SHALL be ineligible until its req is sampled low, which clears its mask bit.
REQ-029 With ARB_TIMEOUT_EN defined, the maximum ownership SHALL be 16 cycles.
REQ-030 Without ARB_TIMEOUT_EN, the counter and mask SHALL be absent, to_evt SHALL be tied 0, and ownership SHALL be unbounded.

Verification
REQ-031 The bench SHALL cover: reset, then req=8'h01, en=1 -> one cycle later gnt_n=8'hFE, gsel=0, busy=1; drop req -> TURN cycle with gnt_n=8'hFF -> IDLE.
REQ-032 The bench SHALL cover: req=8'h81 held constant, each owner dropping and reasserting its request after 3 cycles -> grants alternate 0,7,0,7 with one all-high cycle between them.
REQ-033 The bench SHALL cover: last=6, req=8'h03 -> grant goes to 0, not 1 (wrap), then to 1.
REQ-034 The bench SHALL cover: owner 2 held with en dropped to 0 mid-grant -> grant persists; on release -> IDLE, with no new grant until en=1.
REQ-035 The bench SHALL cover, with ARB_TIMEOUT_EN: req=8'h04 held for 40 cycles -> to_evt pulse after 16 GRANT cycles, gnt_n=8'hFF thereafter until req[2] is sampled low, then regrant allowed.
REQ-036 The bench SHALL cover: reset asserted mid-grant between clock edges -> gnt_n=8'hFF immediately, busy=0.
